// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store port of the core. Only one memory transaction may
// be outstanding at a time; each response is routed back to the requester
// that issued it, and responses to squashed fetches are dropped.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   if_req_*            fetch request (valid/ready/addr), if_flush squashes
//   if_rsp_*            fetch response (valid/data)
//   ls_req_*            load/store request (valid/ready/addr/we/wdata/wstrb)
//   ls_rsp_*            load/store response (valid/data, data 0 for stores)
//   mem_req_*           muxed request to memory (valid/ready/addr/we/wdata/wstrb)
//   mem_rsp_*           memory response (valid/data)
//
// Build options:
//   MEM_ARB_STARVE_GUARD_EN  when defined, a fetch is promoted over load/store
//                            after STARVE_MAX consecutive load/store grants
//                            taken while the fetch was waiting.
//   MEM_ARB_CHECKERS         when defined, instantiates a simulation checker
//                            flagging memory responses that arrive in IDLE.

module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  input  logic                if_flush,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_we,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_LS = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   squash_q, squash_d;
  logic   we_q, we_d;

  logic   free_s;
  logic   if_prio_s;
  logic   grant_if_s;
  logic   grant_ls_s;
  logic   accept_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Starvation counter: counts ls grants taken while a fetch was waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (accept_s && grant_if_s) begin
      starve_cnt_d = '0;
    end else if (accept_s && grant_ls_s) begin
      if (!if_req_valid) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != CNT_MAX) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign if_prio_s = (starve_cnt_q == CNT_MAX);
`else
  // Strict load/store priority; STARVE_MAX only matters with the guard.
  if (STARVE_MAX == 0) begin : g_starve_unused
  end
  assign if_prio_s = 1'b0;
`endif

  // Arbitration and request muxing. Reset gating keeps every output at 0
  // while rst is low, even if requesters keep their valids asserted.
  always_comb begin
    free_s        = rst && ((state_q == IDLE) || mem_rsp_valid);
    grant_if_s    = 1'b0;
    grant_ls_s    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_we    = 1'b0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    if (free_s) begin
      // A flushed fetch is never eligible.
      grant_if_s = if_req_valid && !if_flush && (!ls_req_valid || if_prio_s);
      grant_ls_s = ls_req_valid && !grant_if_s;
    end else begin
      grant_if_s = 1'b0;
      grant_ls_s = 1'b0;
    end
    if (grant_ls_s) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = ls_req_addr;
      mem_req_we    = ls_req_we;
      mem_req_wdata = ls_req_wdata;
      mem_req_wstrb = ls_req_wstrb;
    end else if (grant_if_s) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = if_req_addr;
    end else begin
      mem_req_valid = 1'b0;
    end
  end

  assign accept_s     = mem_req_valid && mem_req_ready;
  assign if_req_ready = accept_s && grant_if_s;
  assign ls_req_ready = accept_s && grant_ls_s;

  // Response routing; store acknowledges return zero data.
  always_comb begin
    if_rsp_valid = rst && (state_q == WAIT_IF) && mem_rsp_valid && !squash_q && !if_flush;
    ls_rsp_valid = rst && (state_q == WAIT_LS) && mem_rsp_valid;
    if_rsp_data  = if_rsp_valid ? mem_rsp_data : '0;
    ls_rsp_data  = (ls_rsp_valid && !we_q) ? mem_rsp_data : '0;
  end

  // Next state, squash flag and registered write bit.
  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    we_d     = we_q;
    if (free_s) begin
      if (accept_s) begin
        state_d = grant_if_s ? WAIT_IF : WAIT_LS;
      end else begin
        state_d = IDLE;
      end
    end else begin
      state_d = state_q;
    end
    // Squash clears on the fetch response, otherwise latches any flush.
    if (state_q == WAIT_IF) begin
      if (mem_rsp_valid) begin
        squash_d = 1'b0;
      end else if (if_flush) begin
        squash_d = 1'b1;
      end else begin
        squash_d = squash_q;
      end
    end else begin
      squash_d = 1'b0;
    end
    if (ls_req_ready) begin
      we_d = ls_req_we;
    end else begin
      we_d = we_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      squash_q <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      we_q     <= we_d;
    end
  end

`ifdef MEM_ARB_CHECKERS
  mem_arbiter_chk u_chk (
    .clk_i       (clk),
    .rst_i       (rst),
    .idle_i      (state_q == IDLE),
    .rsp_valid_i (mem_rsp_valid)
  );
`endif

endmodule

`ifdef MEM_ARB_CHECKERS
// Simulation-only protocol checker: memory must not respond with nothing
// outstanding.
module mem_arbiter_chk (
  input logic clk_i,
  input logic rst_i,
  input logic idle_i,
  input logic rsp_valid_i
);
  // Flag responses that arrive while the arbiter is idle.
  always @(posedge clk_i) begin
    if (rst_i && idle_i && rsp_valid_i) begin
      $error("mem_arbiter: mem_rsp_valid while IDLE");
    end
  end
endmodule
`endif

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a table of single-cycle
// arbitration vectors checked from IDLE, followed by hand-written sequences
// for latency, routing, flush, starvation and mid-transaction reset.

module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              clk;
  logic              rst;
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic [ADDR_W-1:0] ls_req_addr;
  logic              ls_req_we;
  logic [DATA_W-1:0] ls_req_wdata;
  logic [7:0]        ls_req_wstrb;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [7:0]        mem_req_wstrb;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_flush      (if_flush),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_addr   (ls_req_addr),
    .ls_req_we     (ls_req_we),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wstrb  (ls_req_wstrb),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rsp_data   (ls_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifv;
    logic [31:0] ifa;
    logic        fl;
    logic        lsv;
    logic [31:0] lsa;
    logic        we;
    logic [63:0] wd;
    logic [7:0]  ws;
    logic        exp_v;
    logic [31:0] exp_a;
    logic        exp_we;
    logic [63:0] exp_wd;
    logic [7:0]  exp_ws;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid  = 1'b0;
    if_req_addr   = 32'h0;
    if_flush      = 1'b0;
    ls_req_valid  = 1'b0;
    ls_req_addr   = 32'h0;
    ls_req_we     = 1'b0;
    ls_req_wdata  = 64'h0;
    ls_req_wstrb  = 8'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 64'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'h0);
    check({tag, "_if_req_ready"},  64'(if_req_ready),  64'h0);
    check({tag, "_ls_req_ready"},  64'(ls_req_ready),  64'h0);
    check({tag, "_if_rsp_valid"},  64'(if_rsp_valid),  64'h0);
    check({tag, "_ls_rsp_valid"},  64'(ls_rsp_valid),  64'h0);
    check({tag, "_if_rsp_data"},   if_rsp_data,        64'h0);
    check({tag, "_ls_rsp_data"},   ls_rsp_data,        64'h0);
    check({tag, "_mem_req_addr"},  64'(mem_req_addr),  64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    step();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    int grants[6];
    int exp_grant;

    //        ifv   ifa            fl    lsv   lsa         we    wd              ws     ev    ea            ewe   ewd             ews
    vecs[0] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,      1'b0, 64'h0,          8'h0,  1'b0, 32'h0,        1'b0, 64'h0,          8'h0};
    vecs[1] = '{1'b1, 32'h80000000, 1'b0, 1'b0, 32'h300,    1'b1, 64'h5555,       8'hFF, 1'b1, 32'h80000000, 1'b0, 64'h0,          8'h0};
    vecs[2] = '{1'b1, 32'h80000000, 1'b1, 1'b0, 32'h0,      1'b0, 64'h0,          8'h0,  1'b0, 32'h0,        1'b0, 64'h0,          8'h0};
    vecs[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h100,    1'b0, 64'h1111,       8'h00, 1'b1, 32'h100,      1'b0, 64'h1111,       8'h00};
    vecs[4] = '{1'b1, 32'h80000004, 1'b0, 1'b1, 32'h200,    1'b1, 64'hDEADBEEF,   8'h0F, 1'b1, 32'h200,      1'b1, 64'hDEADBEEF,   8'h0F};
    vecs[5] = '{1'b1, 32'h80000004, 1'b1, 1'b1, 32'h208,    1'b0, 64'h0,          8'h00, 1'b1, 32'h208,      1'b0, 64'h0,          8'h00};

    idle_inputs();
    rst = 1'b0;
    #1;
    check_all_zero("reset");
    step();
    rst = 1'b1;
    #1;

    // Combinational arbitration from IDLE with memory not ready (no accept).
    for (int i = 0; i < 6; i++) begin
      if_req_valid = vecs[i].ifv;
      if_req_addr  = vecs[i].ifa;
      if_flush     = vecs[i].fl;
      ls_req_valid = vecs[i].lsv;
      ls_req_addr  = vecs[i].lsa;
      ls_req_we    = vecs[i].we;
      ls_req_wdata = vecs[i].wd;
      ls_req_wstrb = vecs[i].ws;
      #1;
      check($sformatf("vec%0d_valid", i), 64'(mem_req_valid), 64'(vecs[i].exp_v));
      check($sformatf("vec%0d_addr", i),  64'(mem_req_addr),  64'(vecs[i].exp_a));
      check($sformatf("vec%0d_we", i),    64'(mem_req_we),    64'(vecs[i].exp_we));
      check($sformatf("vec%0d_wdata", i), mem_req_wdata,      vecs[i].exp_wd);
      check($sformatf("vec%0d_wstrb", i), 64'(mem_req_wstrb), 64'(vecs[i].exp_ws));
      check($sformatf("vec%0d_ready", i), 64'({if_req_ready, ls_req_ready}), 64'h0);
      step();
    end
    idle_inputs();
    #1;

    // Fetch only, latency 1.
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h80000000;
    mem_req_ready = 1'b1;
    #1;
    check("f1_if_ready", 64'(if_req_ready), 64'h1);
    check("f1_addr", 64'(mem_req_addr), 64'h80000000);
    step();
    if_req_valid  = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h13;
    #1;
    check("f1_rsp_valid", 64'(if_rsp_valid), 64'h1);
    check("f1_rsp_data", if_rsp_data, 64'h13);
    check("f1_ls_rsp", 64'(ls_rsp_valid), 64'h0);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("f1_rsp_done", 64'(if_rsp_valid), 64'h0);

    // Fetch and load together: ls first, fetch accepted on the ls response.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h80000040;
    ls_req_valid = 1'b1;
    ls_req_addr  = 32'h100;
    ls_req_we    = 1'b0;
    #1;
    check("both_ls_ready", 64'(ls_req_ready), 64'h1);
    check("both_if_ready", 64'(if_req_ready), 64'h0);
    check("both_addr", 64'(mem_req_addr), 64'h100);
    step();
    ls_req_valid  = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hAAAA;
    #1;
    check("both_ls_rsp", 64'(ls_rsp_valid), 64'h1);
    check("both_ls_data", ls_rsp_data, 64'hAAAA);
    check("both_if_rsp0", 64'(if_rsp_valid), 64'h0);
    check("both_if_b2b", 64'(if_req_ready), 64'h1);
    check("both_if_addr", 64'(mem_req_addr), 64'h80000040);
    step();
    if_req_valid = 1'b0;
    mem_rsp_data = 64'hBBBB;
    #1;
    check("both_if_rsp", 64'(if_rsp_valid), 64'h1);
    check("both_if_data", if_rsp_data, 64'hBBBB);
    check("both_ls_rsp0", 64'(ls_rsp_valid), 64'h0);
    step();
    mem_rsp_valid = 1'b0;

    // Store: write fields to memory, zero response data.
    ls_req_valid = 1'b1;
    ls_req_addr  = 32'h200;
    ls_req_we    = 1'b1;
    ls_req_wdata = 64'hDEADBEEF;
    ls_req_wstrb = 8'h0F;
    #1;
    check("st_we", 64'(mem_req_we), 64'h1);
    check("st_wdata", mem_req_wdata, 64'hDEADBEEF);
    check("st_wstrb", 64'(mem_req_wstrb), 64'h0F);
    check("st_ready", 64'(ls_req_ready), 64'h1);
    step();
    ls_req_valid  = 1'b0;
    ls_req_we     = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h1234;
    #1;
    check("st_rsp", 64'(ls_rsp_valid), 64'h1);
    check("st_rsp_data", ls_rsp_data, 64'h0);
    step();
    mem_rsp_valid = 1'b0;

    // Fetch latency 3 with flush in cycle 1; next fetch issued on the
    // squashed response returns its own data.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h80000008;
    #1;
    check("fl_accept", 64'(if_req_ready), 64'h1);
    step();
    if_req_valid = 1'b0;
    if_flush     = 1'b1;
    #1;
    check("fl_c1_rsp", 64'(if_rsp_valid), 64'h0);
    step();
    if_flush = 1'b0;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h55;
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h80000010;
    #1;
    check("fl_squashed", 64'(if_rsp_valid), 64'h0);
    check("fl_next_ready", 64'(if_req_ready), 64'h1);
    check("fl_next_addr", 64'(mem_req_addr), 64'h80000010);
    step();
    if_req_valid = 1'b0;
    mem_rsp_data = 64'h77;
    #1;
    check("fl_next_rsp", 64'(if_rsp_valid), 64'h1);
    check("fl_next_data", if_rsp_data, 64'h77);
    step();
    mem_rsp_valid = 1'b0;

    // Flush in the same cycle as the fetch response.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h80000020;
    step();
    if_req_valid  = 1'b0;
    if_flush      = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h99;
    #1;
    check("flsame_rsp", 64'(if_rsp_valid), 64'h0);
    step();
    if_flush      = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    check("flsame_idle_req", 64'(mem_req_valid), 64'h0);

    // Flush never affects a load in flight.
    ls_req_valid = 1'b1;
    ls_req_addr  = 32'h180;
    step();
    ls_req_valid  = 1'b0;
    if_flush      = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h4242;
    #1;
    check("lsfl_rsp", 64'(ls_rsp_valid), 64'h1);
    check("lsfl_data", ls_rsp_data, 64'h4242);
    step();
    if_flush      = 1'b0;
    mem_rsp_valid = 1'b0;

    // Starvation: both held with 1-cycle memory.
    do_reset();
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h80001000;
    ls_req_valid  = 1'b1;
    ls_req_addr   = 32'h400;
    mem_req_ready = 1'b1;
    mem_rsp_data  = 64'h1;
    for (int c = 0; c < 6; c++) begin
      #1;
      grants[c] = ls_req_ready ? 1 : (if_req_ready ? 2 : 0);
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_grant = (c == 4) ? 2 : 1;
`else
      exp_grant = 1;
`endif
      check($sformatf("starve_grant%0d", c), 64'(grants[c]), 64'(exp_grant));
      step();
      mem_rsp_valid = 1'b1;
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    step();
    mem_rsp_valid = 1'b0;

    // Reset asserted while a load is outstanding; late response dropped.
    ls_req_valid = 1'b1;
    ls_req_addr  = 32'h500;
    step();
    ls_req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hCAFE;
    #1;
    check("late_ls_rsp", 64'(ls_rsp_valid), 64'h0);
    check("late_if_rsp", 64'(if_rsp_valid), 64'h0);
    check("late_ls_data", ls_rsp_data, 64'h0);
    step();
    mem_rsp_valid = 1'b0;
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port memory between the core's instruction-fetch port and its load/store port. It sits between the `riscv` core and the unified memory inside `soc`. It enforces a single outstanding memory transaction and routes each response back to the requester that issued it. It also drops responses to squashed fetches.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 64, data width (RV64)
- STARVE_MAX, 4, consecutive load/store grants tolerated while a fetch waits (used only with the guard macro)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_flush  in  1  squash any in-flight fetch; block fetch acceptance this cycle
- if_rsp_valid  out  1  fetch data valid
- if_rsp_data  out  DATA_W  fetch data
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_req_addr  in  ADDR_W  load/store address
- ls_req_we  in  1  1 = store
- ls_req_wdata  in  DATA_W  store data
- ls_req_wstrb  in  DATA_W/8  store byte enables
- ls_rsp_valid  out  1  load data or store acknowledge valid
- ls_rsp_data  out  DATA_W  load data; 0 for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr / mem_req_we / mem_req_wdata / mem_req_wstrb  out  ADDR_W / 1 / DATA_W / DATA_W/8  muxed request fields; fetch drives we=0, wdata=0, wstrb=0
- mem_rsp_valid  in  1  memory response, exactly one per accepted request, latency ≥1
- mem_rsp_data  in  DATA_W  memory read data

## Operation
- States:
  - IDLE: no request outstanding.
  - WAIT_IF: fetch outstanding.
  - WAIT_LS: load/store outstanding.
- "Free" means the state is IDLE, or the state is WAIT_* with mem_rsp_valid=1 in the same cycle.
- Arbitration, evaluated only when free:
  - ls wins over if by default.
  - A fetch is eligible only if if_flush=0.
- mem_req_valid = free && (any eligible request).
- Fields are muxed from the winner.
- Accept is the cycle in which mem_req_valid && mem_req_ready. In that cycle the winner's *_req_ready=1 and the loser's *_req_ready=0.
- After accept, the state becomes WAIT_IF or WAIT_LS.
- Response in WAIT_IF:
  - if_rsp_valid = mem_rsp_valid && !squash && !if_flush, combinational pass-through of the data.
  - squash is a flag set when if_flush=1 is seen in WAIT_IF. It is cleared on the response.
  - On the response, the next state is WAIT_* if a new accept happens in the same cycle, otherwise IDLE.
- Response in WAIT_LS: ls_rsp_valid = mem_rsp_valid. Data is forced to 0 for stores, which requires the registered we bit.
- No response backpressure: requesters always sink responses.
- mem_rsp_valid in IDLE is a protocol error. It is ignored, and with assertions enabled a simulation $error is raised.

## Timing
- Reset values:
  - State IDLE, squash 0, starvation count 0.
  - mem_req_valid 0, if/ls_req_ready 0, if/ls_rsp_valid 0.
  - All data outputs 0.
- Request path: zero-cycle combinational from *_req_valid to mem_req_valid.
- Response path: zero-cycle combinational from mem_rsp_valid to *_rsp_valid.
- Back-to-back: a new request is accepted in the same cycle as the previous response, giving 1 transaction per cycle with 1-cycle latency memory.
- Reset asserted mid-transaction:
  - All state clears immediately.
  - The in-flight memory response after reset release arrives in IDLE and is dropped.
- if_flush in the same cycle as a fetch response suppresses that response.
- if_flush never affects WAIT_LS.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A counter increments on each ls accept while if_req_valid=1.
  - It resets to 0 on any if accept, or when if_req_valid=0 at an ls accept.
  - When count == STARVE_MAX, an eligible fetch wins the next free cycle over ls.
  - The counter saturates at STARVE_MAX.
- MEM_ARB_STARVE_GUARD_EN undefined: strict ls priority, no counter; a fetch can starve indefinitely.

## Test plan
- Fetch only, addr 0x80000000, memory latency 1, data 0x13 → if_rsp_valid one cycle after accept with data 0x13; ls_rsp_valid stays 0.
- if and ls valid together, ls load addr 0x100 → ls accepted first; if accepted in the ls response cycle; each response routed to the correct port.
- Store addr 0x200, wdata 0xDEADBEEF, wstrb 0x0F → memory sees we=1 with those fields; ls_rsp_valid=1 with data 0.
- Fetch accepted, latency 3, if_flush pulsed in cycle 1 → no if_rsp_valid; a subsequent fetch returns its own data correctly.
- Guard on, STARVE_MAX=4, ls_req_valid and if_req_valid held high → grant order ls,ls,ls,ls,if,ls… Guard off → ls only.
- rst low for 1 cycle during WAIT_LS → all outputs 0; the late mem_rsp_valid produces no *_rsp_valid.
